// File: rtl/game_speed_scheduler.sv
// Game-tick scheduler for the color crasher core: drives the tick-rate divider,
// turns its feedback clock into one-cycle game ticks, and sequences level-up,
// pause and crash-recovery phases.
module game_speed_scheduler #(
  parameter int unsigned START_HZ        = 2,
  parameter int unsigned STEP_HZ         = 2,
  parameter int unsigned MAX_HZ          = 60,
  parameter int unsigned MAX_LEVEL       = 15,
  parameter int unsigned TICKS_PER_LEVEL = 32,
  parameter int unsigned SLOW_HZ         = 1,
  parameter int unsigned CRASH_HOLD      = 4
) (
  input  logic        inClock,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        levelUp,
  input  logic        crash,
  input  logic        gameClock,
  output logic [19:0] speed,
  output logic        divReset,
  output logic        tick,
  output logic [3:0]  level,
  output logic        running,
  output logic        crashed
);

  localparam int unsigned SPEED_W = 20;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned TC_W    = $clog2(TICKS_PER_LEVEL + 1);
  localparam int unsigned CC_W    = $clog2(CRASH_HOLD + 1);

  localparam logic [TC_W-1:0]    TC_LAST     = TC_W'(TICKS_PER_LEVEL - 1);
  localparam logic [CC_W-1:0]    CC_LAST     = CC_W'(CRASH_HOLD - 1);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP   = LEVEL_W'(MAX_LEVEL);
  localparam logic [SPEED_W-1:0] SPEED_START = SPEED_W'(START_HZ);
  localparam logic [SPEED_W-1:0] SPEED_SLOW  = SPEED_W'(SLOW_HZ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSED,
    S_CRASHED
  } state_e;

  state_e               state_q, state_d;
  logic [SPEED_W-1:0]   speed_q, speed_d;
  logic                 div_reset_q, div_reset_d;
  logic                 tick_q, tick_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic                 running_q, running_d;
  logic                 crashed_q, crashed_d;
  logic [TC_W-1:0]      tick_count_q, tick_count_d;
  logic [CC_W-1:0]      crash_count_q, crash_count_d;
  logic                 gc_prev_q, gc_prev_d;

  logic                 gc_edge_c;
  logic                 auto_up_c;

  // Clamped tick rate for a level; 32-bit arithmetic, truncated after the clamp.
  function automatic logic [SPEED_W-1:0] rate_f(input logic [LEVEL_W-1:0] lvl);
    logic [31:0] r;
    r = START_HZ + (32'(lvl) * STEP_HZ);
    if (r > MAX_HZ) begin
      r = MAX_HZ;
    end
    return SPEED_W'(r);
  endfunction

  // Rising edge of the divider output, and the edge that completes a level.
  assign gc_edge_c = gameClock & ~gc_prev_q;
  assign auto_up_c = gc_edge_c && (tick_count_q == TC_LAST);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    speed_d       = speed_q;
    level_d       = level_q;
    tick_count_d  = tick_count_q;
    crash_count_d = crash_count_q;
    tick_d        = 1'b0;
    gc_prev_d     = div_reset_q ? 1'b0 : gameClock;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        speed_d = rate_f(level_q);
        state_d = S_RUN;
      end

      S_RUN: begin
        if (crash) begin
          // An edge arriving with the crash is swallowed.
          state_d       = S_CRASHED;
          speed_d       = SPEED_SLOW;
          crash_count_d = '0;
        end else begin
          tick_d = gc_edge_c;
          if (gc_edge_c) begin
            tick_count_d = tick_count_q + TC_W'(1);
          end
          if (pause) begin
            state_d = S_PAUSED;
          end else if (levelUp || auto_up_c) begin
            if (level_q < LEVEL_TOP) begin
              level_d      = level_q + LEVEL_W'(1);
              tick_count_d = '0;
              state_d      = S_LOAD;
            end else if (auto_up_c) begin
              tick_count_d = '0;
            end
          end
        end
      end

      S_PAUSED: begin
        if (crash) begin
          state_d       = S_CRASHED;
          speed_d       = SPEED_SLOW;
          crash_count_d = '0;
        end else if (!pause) begin
          state_d = S_LOAD;
        end
      end

      S_CRASHED: begin
        if (gc_edge_c) begin
          if (crash_count_q == CC_LAST) begin
            state_d      = S_IDLE;
            level_d      = '0;
            tick_count_d = '0;
            speed_d      = SPEED_START;
          end else begin
            crash_count_d = crash_count_q + CC_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags follow the state being entered; the divider runs only in
    // RUN and in CRASHED after its entry cycle.
    running_d   = (state_d == S_RUN);
    crashed_d   = (state_d == S_CRASHED);
    div_reset_d = !((state_d == S_RUN) ||
                    ((state_d == S_CRASHED) && (state_q == S_CRASHED)));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge inClock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      speed_q       <= SPEED_START;
      div_reset_q   <= 1'b1;
      tick_q        <= 1'b0;
      level_q       <= '0;
      running_q     <= 1'b0;
      crashed_q     <= 1'b0;
      tick_count_q  <= '0;
      crash_count_q <= '0;
      gc_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      speed_q       <= speed_d;
      div_reset_q   <= div_reset_d;
      tick_q        <= tick_d;
      level_q       <= level_d;
      running_q     <= running_d;
      crashed_q     <= crashed_d;
      tick_count_q  <= tick_count_d;
      crash_count_q <= crash_count_d;
      gc_prev_q     <= gc_prev_d;
    end
  end

  assign speed    = speed_q;
  assign divReset = div_reset_q;
  assign tick     = tick_q;
  assign level    = level_q;
  assign running  = running_q;
  assign crashed  = crashed_q;

endmodule

// File: tb/tb_game_speed_scheduler.sv
// Bench for game_speed_scheduler: phase-level reference model compared every
// cycle, a divider stand-in on gameClock, and directed scenarios with literals.
module tb_game_speed_scheduler;

  localparam int START_HZ = 2;
  localparam int STEP_HZ  = 2;
  localparam int MAX_HZ   = 60;
  localparam int MAX_LVL  = 15;
  localparam int TPL      = 32;
  localparam int SLOW_HZ  = 1;
  localparam int HOLD     = 4;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_PAUSE = 3;
  localparam int P_CRASH = 4;

  logic        inClock;
  logic        reset;
  logic        start;
  logic        pause;
  logic        levelUp;
  logic        crash;
  logic        gameClock;
  logic [19:0] speed;
  logic        divReset;
  logic        tick;
  logic [3:0]  level;
  logic        running;
  logic        crashed;

  game_speed_scheduler #(
    .START_HZ(START_HZ), .STEP_HZ(STEP_HZ), .MAX_HZ(MAX_HZ), .MAX_LEVEL(MAX_LVL),
    .TICKS_PER_LEVEL(TPL), .SLOW_HZ(SLOW_HZ), .CRASH_HOLD(HOLD)
  ) dut (
    .inClock(inClock), .reset(reset), .start(start), .pause(pause),
    .levelUp(levelUp), .crash(crash), .gameClock(gameClock),
    .speed(speed), .divReset(divReset), .tick(tick), .level(level),
    .running(running), .crashed(crashed)
  );

  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int  m_phase, m_level, m_ticks, m_cedges, m_speed;
  bit  m_gc_prev, m_valid;
  bit  e_div, e_tick, e_run, e_crash;
  bit  m_rise, m_entry;

  function automatic int rate_of(input int l);
    int r;
    r = START_HZ + l * STEP_HZ;
    return (r > MAX_HZ) ? MAX_HZ : r;
  endfunction

  initial m_valid = 1'b0;

  always @(posedge inClock) begin
    if (reset) begin
      m_phase = P_IDLE; m_level = 0; m_ticks = 0; m_cedges = 0;
      m_speed = START_HZ; m_gc_prev = 1'b0;
      e_div = 1'b1; e_tick = 1'b0; e_run = 1'b0; e_crash = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_rise    = gameClock && !m_gc_prev;
      m_gc_prev = e_div ? 1'b0 : gameClock;
      e_tick    = 1'b0;
      m_entry   = 1'b0;
      case (m_phase)
        P_IDLE: if (start) m_phase = P_LOAD;
        P_LOAD: begin
          m_speed = rate_of(m_level);
          m_phase = P_RUN;
        end
        P_RUN: begin
          if (crash) begin
            m_phase = P_CRASH; m_entry = 1'b1; m_speed = SLOW_HZ; m_cedges = 0;
          end else begin
            // Every edge ticks, even when pause or a level change also happens.
            e_tick = m_rise;
            if (pause) begin
              if (m_rise) m_ticks++;
              m_phase = P_PAUSE;
            end else if (levelUp || (m_rise && m_ticks == TPL - 1)) begin
              if (m_level < MAX_LVL) begin
                m_level++; m_ticks = 0; m_phase = P_LOAD;
              end else if (m_rise) begin
                m_ticks = (m_ticks == TPL - 1) ? 0 : m_ticks + 1;
              end
            end else if (m_rise) begin
              m_ticks++;
            end
          end
        end
        P_PAUSE: begin
          if (crash) begin
            m_phase = P_CRASH; m_entry = 1'b1; m_speed = SLOW_HZ; m_cedges = 0;
          end else if (!pause) begin
            m_phase = P_LOAD;
          end
        end
        default: begin
          if (m_rise) begin
            m_cedges++;
            if (m_cedges == HOLD) begin
              m_phase = P_IDLE; m_level = 0; m_ticks = 0; m_speed = START_HZ;
            end
          end
        end
      endcase
      e_run   = (m_phase == P_RUN);
      e_crash = (m_phase == P_CRASH);
      e_div   = !(m_phase == P_RUN || (m_phase == P_CRASH && !m_entry));
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge inClock) begin
    if (m_valid) begin
      chk("cyc_speed", 32'(speed), 32'(m_speed));
      chk("cyc_divReset", 32'(divReset), 32'(e_div));
      chk("cyc_tick", 32'(tick), 32'(e_tick));
      chk("cyc_level", 32'(level), 32'(m_level));
      chk("cyc_running", 32'(running), 32'(e_run));
      chk("cyc_crashed", 32'(crashed), 32'(e_crash));
    end
  end

  // ---------------- stimulus ----------------
  int gc_cnt = 0;
  int tick_seen = 0;

  // Advance one cycle: clear one-cycle pulses, emulate a period-10 divider
  // that is held low and restarted while divReset is high, count ticks.
  task automatic step();
    @(negedge inClock);
    start = 1'b0; levelUp = 1'b0; crash = 1'b0;
    if (divReset !== 1'b0) begin
      gc_cnt = 0; gameClock = 1'b0;
    end else begin
      gc_cnt = (gc_cnt + 1) % 10;
      gameClock = (gc_cnt >= 5);
    end
    if (tick === 1'b1) tick_seen++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_speed"}, 32'(speed), 32'd2);
    chk({tag, "_divReset"}, 32'(divReset), 32'd1);
    chk({tag, "_tick"}, 32'(tick), 32'd0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_crashed"}, 32'(crashed), 32'd0);
  endtask

  task automatic wait_running(input string tag);
    for (int g = 0; g < 30 && running !== 1'b1; g++) step();
    chk(tag, 32'(running), 32'd1);
  endtask

  int prev_level;
  bit was_max;

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; levelUp = 1'b0; crash = 1'b0;
    gameClock = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst0");
    reset = 1'b0;

    // 1: start latency and one tick per divider period
    step();
    start = 1'b1;
    step();
    chk("load_divReset", 32'(divReset), 32'd1);
    step();
    chk("t1_running", 32'(running), 32'd1);
    chk("t1_speed", 32'(speed), 32'd2);
    chk("t1_divReset", 32'(divReset), 32'd0);
    chk("t1_level", 32'(level), 32'd0);
    tick_seen = 0;
    repeat (100) step();
    chk("t1_ticks_100cyc", 32'(tick_seen), 32'd10);

    // 2: automatic level-up after 32 edges
    for (int g = 0; g < 500 && level !== 4'd1; g++) step();
    chk("t2_level1", 32'(level), 32'd1);
    chk("t2_load_divReset", 32'(divReset), 32'd1);
    chk("t2_load_running", 32'(running), 32'd0);
    step();
    chk("t2_speed4", 32'(speed), 32'd4);
    chk("t2_run", 32'(running), 32'd1);
    tick_seen = 0;
    for (int g = 0; g < 500 && level !== 4'd2; g++) step();
    chk("t2_level2", 32'(level), 32'd2);
    chk("t2_ticks_per_level", 32'(tick_seen), 32'd32);

    // 3: forced level-ups saturate at the top level
    for (int i = 0; i < 40; i++) begin
      wait_running("t3_run_wait");
      prev_level = int'(level);
      was_max = (level == 4'd15);
      levelUp = 1'b1;
      step();
      if (was_max) begin
        chk("t3_max_no_divReset", 32'(divReset), 32'd0);
        chk("t3_max_still_run", 32'(running), 32'd1);
      end else begin
        chk("t3_level_inc", 32'(level), 32'(prev_level + 1));
      end
      step();
    end
    chk("t3_level15", 32'(level), 32'd15);
    chk("t3_speed32", 32'(speed), 32'd32);

    // 4: pause holds state, release reloads the same speed
    wait_running("t4_run_wait");
    prev_level = int'(level);
    pause = 1'b1;
    repeat (20) step();
    chk("t4_level_held", 32'(level), 32'(prev_level));
    chk("t4_divReset", 32'(divReset), 32'd1);
    chk("t4_running", 32'(running), 32'd0);
    chk("t4_tick", 32'(tick), 32'd0);
    pause = 1'b0;
    step();
    chk("t4_load_divReset", 32'(divReset), 32'd1);
    chk("t4_load_running", 32'(running), 32'd0);
    step();
    chk("t4_resume_run", 32'(running), 32'd1);
    chk("t4_resume_speed", 32'(speed), 32'd32);

    // 5: crash on a divider edge, hold for four edges, ignore start
    for (int g = 0; g < 30 && gc_cnt != 4; g++) step();
    step();
    chk("t5_gc_rising", 32'(gameClock), 32'd1);
    crash = 1'b1;
    step();
    chk("t5_crashed", 32'(crashed), 32'd1);
    chk("t5_no_tick", 32'(tick), 32'd0);
    chk("t5_speed1", 32'(speed), 32'd1);
    chk("t5_entry_divReset", 32'(divReset), 32'd1);
    for (int g = 0; g < 200 && crashed !== 1'b0; g++) begin
      if (g % 2 == 1) start = 1'b1;
      step();
    end
    chk("t5_back_idle", 32'(crashed), 32'd0);
    chk("t5_level0", 32'(level), 32'd0);
    chk("t5_speed2", 32'(speed), 32'd2);
    chk("t5_idle_divReset", 32'(divReset), 32'd1);
    step();
    chk("t5_start_ignored", 32'(running), 32'd0);

    // 6: reset from CRASHED and PAUSED; start with crash in IDLE
    start = 1'b1;
    step();
    step();
    crash = 1'b1;
    step();
    chk("t6_in_crash", 32'(crashed), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_vals("t6_rst_crash");
    reset = 1'b0;
    step();
    start = 1'b1;
    step();
    step();
    levelUp = 1'b1;
    step();
    step();
    pause = 1'b1;
    step();
    step();
    chk("t6_paused_level", 32'(level), 32'd1);
    chk("t6_paused_divReset", 32'(divReset), 32'd1);
    reset = 1'b1;
    step();
    chk_reset_vals("t6_rst_pause");
    reset = 1'b0;
    pause = 1'b0;
    step();
    start = 1'b1;
    crash = 1'b1;
    step();
    chk("t6_load_not_crashed", 32'(crashed), 32'd0);
    chk("t6_load_divReset", 32'(divReset), 32'd1);
    step();
    chk("t6_run_after_load", 32'(running), 32'd1);
    chk("t6_run_speed", 32'(speed), 32'd2);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/game_speed_scheduler.md
Name: game_speed_scheduler

Overview:
Sequences the game-tick clock divider for the color crasher core. It drives the divider's speed and reset inputs and watches the divider's output clock. It turns that output into one-cycle game ticks, raises the level (tick rate) over time or on request, and handles pause and crash-recovery phases. All logic runs in the inClock domain; the divider output is sampled as an ordinary synchronous signal.

Parameters:
START_HZ, 2, tick rate at level 0 (must be >= 1)
STEP_HZ, 2, rate increase per level
MAX_HZ, 60, clamp for computed rate
MAX_LEVEL, 15, highest level (fits in level port)
TICKS_PER_LEVEL, 32, game ticks per automatic level-up (>= 1)
SLOW_HZ, 1, rate used during crash hold (must be >= 1)
CRASH_HOLD, 4, game ticks spent in CRASHED before returning to IDLE

Ports:
inClock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin a game (sampled in IDLE only)
pause  in  1  level-sensitive pause request
levelUp  in  1  one-cycle pulse: force next level
crash  in  1  one-cycle pulse: collision event
gameClock  in  1  divider output fed back
speed  out  20  rate to divider, Hz
divReset  out  1  reset to divider
tick  out  1  one-cycle game tick pulse
level  out  4  current level
running  out  1  high in RUN only
crashed  out  1  high in CRASHED only

Behaviour:
- Reset: reset is synchronous, active-high; clock is inClock. Reset forces IDLE, level=0, speed=START_HZ, divReset=1, tick=0, running=0, crashed=0, tickCount=0, crashCount=0, gcPrev=0. Reset mid-game has the same effect, with no partial state kept.
- All outputs are registered.
- Rate function: rate(L) = min(START_HZ + L*STEP_HZ, MAX_HZ), computed at 32-bit width and truncated to 20 bits after clamping. speed is never 0.
- Edge detect: gcPrev <= gameClock each cycle. gcPrev is forced to 0 in any cycle where divReset=1. edge = gameClock & ~gcPrev.
- IDLE: divReset=1, tick=0. start=1 -> LOAD. crash, levelUp and pause are ignored.
- LOAD (exactly 1 cycle): speed <= rate(level), divReset=1. Next state is RUN. The divider therefore restarts phase on every rate change.
- RUN: divReset=0, running=1. Each edge gives tick=1 on the following cycle, for exactly 1 cycle, and tickCount++.
- RUN priority, highest first:
  1. crash -> CRASHED.
  2. pause=1 -> PAUSED.
  3. Level-up, from levelUp=1, or from an edge while tickCount==TICKS_PER_LEVEL-1. If level<MAX_LEVEL: level++, tickCount=0, go to LOAD. If level==MAX_LEVEL: stay in RUN, and the auto case only clears tickCount.
  4. Otherwise stay in RUN.
- PAUSED: divReset=1, tick=0. level, tickCount and speed are held. crash -> CRASHED. pause=0 -> LOAD.
- CRASHED: on entry, speed <= SLOW_HZ, divReset=1 for the entry cycle and then 0, crashed=1, crashCount=0. tick stays 0.
  - Each edge increments crashCount. The edge that makes crashCount reach CRASH_HOLD moves to IDLE with level=0 and tickCount=0.
  - On return to IDLE, speed <= START_HZ.
  - start, pause, levelUp and further crash pulses are ignored.
- Simultaneous events:
  - crash beats everything.
  - An edge coinciding with crash does not produce a tick.
  - An edge coinciding with pause still produces its tick and tickCount increment.
  - levelUp coinciding with an auto level-up counts as one level.
- Latency: start at cycle N (in IDLE) gives LOAD at N+1, then speed valid, divReset=0 and running=1 at N+2.

Test Plan:
1. Reset, then start pulse -> cycle+2: speed=2, divReset=0, running=1, level=0. Feed gameClock with a 10-cycle period -> exactly one tick per period, 1 cycle wide.
2. Defaults, 32 edges in RUN -> level=1, one LOAD cycle with divReset=1, speed=4. tickCount restarts, so the next level-up comes 32 edges later.
3. 40 levelUp pulses during RUN -> level saturates at 15, speed=min(2+30,60)=32. The levelUp pulses arriving while level==15 cause no LOAD and no divReset.
4. pause=1 for 20 cycles mid-RUN -> divReset=1, tick=0, level/tickCount held. On release: one LOAD cycle, then RUN at the same speed.
5. crash with a simultaneous edge in RUN -> no tick, crashed=1, speed=1. After 4 edges -> IDLE, level=0, speed=2. start pulses during CRASHED are ignored.
6. Assert reset while in CRASHED and again while in PAUSED -> every output returns to its reset value on the next cycle. A start in IDLE together with a crash -> LOAD.
